// File: rtl/ip_codma_pkg.sv
// Shared types and size-code helpers for the CODMA bus engines.
package ip_codma_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned SIZE_W     = 4;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned NUM_WORDS  = 8;
  localparam int unsigned BEAT_CNT_W = 2;
  localparam int unsigned TMO_W      = 16;

  typedef enum logic [2:0] {
    RD_IDLE    = 3'd0,
    RD_REQ     = 3'd1,
    RD_GRANTED = 3'd2,
    RD_DONE    = 3'd3,
    RD_ERROR   = 3'd4
  } read_state_t;

  localparam logic [SIZE_W-1:0] SZ_8B  = 4'd3;
  localparam logic [SIZE_W-1:0] SZ_16B = 4'd8;
  localparam logic [SIZE_W-1:0] SZ_32B = 4'd9;

  // Beats per burst for a size code; 0 marks an unsupported code.
  function automatic logic [2:0] beats_of(input logic [SIZE_W-1:0] size);
    case (size)
      SZ_8B:   beats_of = 3'd1;
      SZ_16B:  beats_of = 3'd2;
      SZ_32B:  beats_of = 3'd4;
      default: beats_of = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/ip_codma_timeout_ctr.sv
// Saturating 16-bit cycle counter with a registered expiry flag.
module ip_codma_timeout_ctr
  import ip_codma_pkg::*;
#(
  parameter logic [15:0] LIMIT = 16'd255
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);

  logic [TMO_W-1:0] count_q, count_d;
  logic             expired_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + 16'd1;
    end
  end

  // Flag tracks the next count so it always equals (count_q >= LIMIT).
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= (count_d >= LIMIT);
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/ip_codma_read_machine.sv
// Single-burst bus read engine: issues one request, packs beats into an
// 8x32 data register and reports done/error back to the main control FSM.
module ip_codma_read_machine
  import ip_codma_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             need_read_i,
  input  logic [ADDR_W-1:0]                reg_addr,
  input  logic [SIZE_W-1:0]                reg_size,
  output logic                             need_read_o,
  output logic [NUM_WORDS-1:0][WORD_W-1:0] data_reg,
  output read_state_t                      rd_state_r,
  output read_state_t                      rd_state_next_s,
  output logic                             rd_state_error,
  input  logic                             abort_i,
  output logic                             bus_req_o,
  output logic [ADDR_W-1:0]                bus_addr_o,
  output logic [SIZE_W-1:0]                bus_size_o,
  input  logic                             bus_gnt_i,
  input  logic                             bus_rvalid_i,
  input  logic [DATA_W-1:0]                bus_rdata_i,
  input  logic                             bus_error_i
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);

  read_state_t                      state_q, state_d;
  logic [NUM_WORDS-1:0][WORD_W-1:0] data_q, data_d;
  logic [BEAT_CNT_W-1:0]            beat_q, beat_d;
  logic [ADDR_W-1:0]                addr_q, addr_d;
  logic [SIZE_W-1:0]                size_q, size_d;
  logic                             need_read_q, need_read_d;
  logic                             bus_req_q, bus_req_d;
  logic                             err_q, err_d;
  logic                             tmo_expired;
  logic                             last_beat;

  ip_codma_timeout_ctr #(
    .LIMIT (TMO_LIMIT)
  ) u_tmo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      ((state_q == RD_REQ) || (state_q == RD_GRANTED)),
    .clr_i     (state_q == RD_IDLE),
    .expired_o (tmo_expired)
  );

  assign last_beat = (beat_q == BEAT_CNT_W'(beats_of(size_q) - 3'd1));

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    size_d  = size_q;

    case (state_q)
      RD_IDLE: begin
        if (need_read_i) begin
          addr_d  = reg_addr;
          size_d  = reg_size;
          state_d = (beats_of(reg_size) != 3'd0) ? RD_REQ : RD_ERROR;
        end
      end
      RD_REQ: begin
        if (bus_error_i || tmo_expired) begin
          state_d = RD_ERROR;
        end else if (bus_gnt_i) begin
          state_d = RD_GRANTED;
          beat_d  = '0;
        end else if (abort_i) begin
          state_d = RD_IDLE;
        end
      end
      RD_GRANTED: begin
        if (bus_error_i || tmo_expired) begin
          state_d = RD_ERROR;
        end else if (bus_rvalid_i) begin
          data_d[{beat_q, 1'b0}] = bus_rdata_i[31:0];
          data_d[{beat_q, 1'b1}] = bus_rdata_i[63:32];
          beat_d                 = beat_q + 2'd1;
          if (last_beat) begin
            state_d = RD_DONE;
          end
        end
      end
      RD_DONE:  state_d = RD_IDLE;
      RD_ERROR: state_d = RD_IDLE;
      default:  state_d = RD_IDLE;
    endcase

    need_read_d = (state_d == RD_REQ) || (state_d == RD_GRANTED);
    bus_req_d   = (state_d == RD_REQ);
    err_d       = (state_d == RD_ERROR);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= RD_IDLE;
      data_q      <= '0;
      beat_q      <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      need_read_q <= 1'b0;
      bus_req_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      beat_q      <= beat_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      need_read_q <= need_read_d;
      bus_req_q   <= bus_req_d;
      err_q       <= err_d;
    end
  end

  assign rd_state_r      = state_q;
  assign rd_state_next_s = state_d;
  assign data_reg        = data_q;
  assign need_read_o     = need_read_q;
  assign bus_req_o       = bus_req_q;
  assign bus_addr_o      = addr_q;
  assign bus_size_o      = size_q;
  assign rd_state_error  = err_q;

endmodule

// File: tb/tb_ip_codma_read_machine.sv
// Directed bench for the CODMA read machine, built with an 8-cycle timeout.
module tb_ip_codma_read_machine;
  import ip_codma_pkg::*;

  logic                             clk_i = 1'b0;
  logic                             reset_n_i;
  logic                             need_read_i;
  logic [31:0]                      reg_addr;
  logic [3:0]                       reg_size;
  logic                             need_read_o;
  logic [NUM_WORDS-1:0][WORD_W-1:0] data_reg;
  read_state_t                      rd_state_r;
  read_state_t                      rd_state_next_s;
  logic                             rd_state_error;
  logic                             abort_i;
  logic                             bus_req_o;
  logic [31:0]                      bus_addr_o;
  logic [3:0]                       bus_size_o;
  logic                             bus_gnt_i;
  logic                             bus_rvalid_i;
  logic [63:0]                      bus_rdata_i;
  logic                             bus_error_i;

  int n_cmp = 0;
  int n_bad = 0;
  int err_pulses = 0;
  int done_cycles = 0;

  ip_codma_read_machine #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .need_read_i     (need_read_i),
    .reg_addr        (reg_addr),
    .reg_size        (reg_size),
    .need_read_o     (need_read_o),
    .data_reg        (data_reg),
    .rd_state_r      (rd_state_r),
    .rd_state_next_s (rd_state_next_s),
    .rd_state_error  (rd_state_error),
    .abort_i         (abort_i),
    .bus_req_o       (bus_req_o),
    .bus_addr_o      (bus_addr_o),
    .bus_size_o      (bus_size_o),
    .bus_gnt_i       (bus_gnt_i),
    .bus_rvalid_i    (bus_rvalid_i),
    .bus_rdata_i     (bus_rdata_i),
    .bus_error_i     (bus_error_i)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (rd_state_error) err_pulses++;
    if (rd_state_r == RD_DONE) done_cycles++;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int d0;
    reset_n_i = 1'b0; need_read_i = 1'b0; reg_addr = '0; reg_size = '0;
    abort_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    bus_rdata_i = '0; bus_error_i = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_state", 64'(rd_state_r), 64'(RD_IDLE));
    chk("rst_need", 64'(need_read_o), 64'd0);
    chk("rst_req", 64'(bus_req_o), 64'd0);
    chk("rst_err", 64'(rd_state_error), 64'd0);
    chk("rst_addr", 64'(bus_addr_o), 64'd0);
    chk("rst_data_lo", 64'(data_reg[0]), 64'd0);
    chk("rst_data_hi", 64'(data_reg[7]), 64'd0);
    reset_n_i = 1'b1;

    // Size 3, grant after 2 waiting cycles
    need_read_i = 1'b1; reg_addr = 32'h100; reg_size = 4'd3;
    tick();
    need_read_i = 1'b0;
    chk("t1_state_req", 64'(rd_state_r), 64'(RD_REQ));
    chk("t1_need_hi", 64'(need_read_o), 64'd1);
    chk("t1_req", 64'(bus_req_o), 64'd1);
    chk("t1_addr", 64'(bus_addr_o), 64'h100);
    chk("t1_size", 64'(bus_size_o), 64'd3);
    tick(); tick();
    chk("t1_still_req", 64'(rd_state_r), 64'(RD_REQ));
    bus_gnt_i = 1'b1;
    #1 chk("t1_next_gnt", 64'(rd_state_next_s), 64'(RD_GRANTED));
    tick();
    bus_gnt_i = 1'b0;
    chk("t1_granted", 64'(rd_state_r), 64'(RD_GRANTED));
    chk("t1_req_drop", 64'(bus_req_o), 64'd0);
    bus_rvalid_i = 1'b1; bus_rdata_i = 64'h11112222_33334444;
    #1 chk("t1_next_done", 64'(rd_state_next_s), 64'(RD_DONE));
    tick();
    bus_rvalid_i = 1'b0;
    chk("t1_done", 64'(rd_state_r), 64'(RD_DONE));
    chk("t1_need_lo", 64'(need_read_o), 64'd0);
    chk("t1_w0", 64'(data_reg[0]), 64'h33334444);
    chk("t1_w1", 64'(data_reg[1]), 64'h11112222);
    tick();
    chk("t1_idle", 64'(rd_state_r), 64'(RD_IDLE));

    // Size 9, four beats with a wait cycle between beats 2 and 3
    e0 = err_pulses; d0 = done_cycles;
    need_read_i = 1'b1; reg_addr = 32'h200; reg_size = 4'd9;
    tick();
    need_read_i = 1'b0; bus_gnt_i = 1'b1;
    tick();
    bus_gnt_i = 1'b0;
    chk("t2_granted", 64'(rd_state_r), 64'(RD_GRANTED));
    bus_rvalid_i = 1'b1; bus_rdata_i = 64'hC0DE0001_C0DE0000;
    tick();
    bus_rdata_i = 64'hC0DE0003_C0DE0002;
    tick();
    bus_rvalid_i = 1'b0;
    tick();
    chk("t2_wait_granted", 64'(rd_state_r), 64'(RD_GRANTED));
    bus_rvalid_i = 1'b1; bus_rdata_i = 64'hC0DE0005_C0DE0004;
    tick();
    bus_rdata_i = 64'hC0DE0007_C0DE0006;
    tick();
    bus_rvalid_i = 1'b0;
    chk("t2_done", 64'(rd_state_r), 64'(RD_DONE));
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_w%0d", i), 64'(data_reg[i]), 64'(32'hC0DE0000 + 32'(i)));
    end
    tick();
    chk("t2_idle", 64'(rd_state_r), 64'(RD_IDLE));
    chk("t2_one_done", 64'(done_cycles - d0), 64'd1);
    chk("t2_no_err", 64'(err_pulses - e0), 64'd0);

    // Timeout: size 8, grant never arrives
    e0 = err_pulses;
    need_read_i = 1'b1; reg_addr = 32'h280; reg_size = 4'd8;
    tick();
    need_read_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("t3_req_c%0d", i), 64'(rd_state_r), 64'(RD_REQ));
      if (i < 8) tick();
    end
    chk("t3_next_err", 64'(rd_state_next_s), 64'(RD_ERROR));
    tick();
    chk("t3_error", 64'(rd_state_r), 64'(RD_ERROR));
    chk("t3_err_pulse", 64'(rd_state_error), 64'd1);
    chk("t3_req_lo", 64'(bus_req_o), 64'd0);
    chk("t3_need_lo", 64'(need_read_o), 64'd0);
    tick();
    chk("t3_idle", 64'(rd_state_r), 64'(RD_IDLE));
    chk("t3_err_gone", 64'(rd_state_error), 64'd0);
    chk("t3_one_pulse", 64'(err_pulses - e0), 64'd1);

    // Bus error together with the first beat
    e0 = err_pulses;
    need_read_i = 1'b1; reg_addr = 32'h300; reg_size = 4'd8;
    tick();
    need_read_i = 1'b0; bus_gnt_i = 1'b1;
    tick();
    bus_gnt_i = 1'b0;
    bus_rvalid_i = 1'b1; bus_error_i = 1'b1; bus_rdata_i = 64'hDEADBEEF_DEADBEEF;
    #1 chk("t4_next_err", 64'(rd_state_next_s), 64'(RD_ERROR));
    tick();
    bus_rvalid_i = 1'b0; bus_error_i = 1'b0;
    chk("t4_error", 64'(rd_state_r), 64'(RD_ERROR));
    chk("t4_need_lo", 64'(need_read_o), 64'd0);
    chk("t4_w0_kept", 64'(data_reg[0]), 64'hC0DE0000);
    chk("t4_w1_kept", 64'(data_reg[1]), 64'hC0DE0001);
    tick();
    chk("t4_one_pulse", 64'(err_pulses - e0), 64'd1);

    // Illegal size code 5
    e0 = err_pulses;
    need_read_i = 1'b1; reg_addr = 32'h400; reg_size = 4'd5;
    #1 chk("t5_next_err", 64'(rd_state_next_s), 64'(RD_ERROR));
    tick();
    need_read_i = 1'b0;
    chk("t5_error", 64'(rd_state_r), 64'(RD_ERROR));
    chk("t5_pulse", 64'(rd_state_error), 64'd1);
    chk("t5_no_req", 64'(bus_req_o), 64'd0);
    tick();
    chk("t5_idle", 64'(rd_state_r), 64'(RD_IDLE));
    chk("t5_one_pulse", 64'(err_pulses - e0), 64'd1);

    // Abort while requesting
    e0 = err_pulses;
    need_read_i = 1'b1; reg_addr = 32'h500; reg_size = 4'd3;
    tick();
    need_read_i = 1'b0; abort_i = 1'b1;
    #1 chk("t6_next_idle", 64'(rd_state_next_s), 64'(RD_IDLE));
    tick();
    abort_i = 1'b0;
    chk("t6_idle", 64'(rd_state_r), 64'(RD_IDLE));
    chk("t6_need_lo", 64'(need_read_o), 64'd0);
    chk("t6_req_lo", 64'(bus_req_o), 64'd0);
    tick();
    chk("t6_no_pulse", 64'(err_pulses - e0), 64'd0);

    // Reset in the middle of a burst, then a normal command
    need_read_i = 1'b1; reg_addr = 32'h600; reg_size = 4'd9;
    tick();
    need_read_i = 1'b0; bus_gnt_i = 1'b1;
    tick();
    bus_gnt_i = 1'b0;
    bus_rvalid_i = 1'b1; bus_rdata_i = 64'h55556666_77778888;
    tick();
    bus_rvalid_i = 1'b0;
    chk("t7_mid_granted", 64'(rd_state_r), 64'(RD_GRANTED));
    reset_n_i = 1'b0;
    #1;
    chk("t7_rst_state", 64'(rd_state_r), 64'(RD_IDLE));
    chk("t7_rst_need", 64'(need_read_o), 64'd0);
    chk("t7_rst_addr", 64'(bus_addr_o), 64'd0);
    chk("t7_rst_w0", 64'(data_reg[0]), 64'd0);
    tick();
    reset_n_i = 1'b1;
    need_read_i = 1'b1; reg_addr = 32'h700; reg_size = 4'd3;
    tick();
    need_read_i = 1'b0; bus_gnt_i = 1'b1;
    chk("t7_addr", 64'(bus_addr_o), 64'h700);
    tick();
    bus_gnt_i = 1'b0;
    bus_rvalid_i = 1'b1; bus_rdata_i = 64'h9999AAAA_BBBBCCCC;
    tick();
    bus_rvalid_i = 1'b0;
    chk("t7_done", 64'(rd_state_r), 64'(RD_DONE));
    chk("t7_w0", 64'(data_reg[0]), 64'hBBBBCCCC);
    chk("t7_w1", 64'(data_reg[1]), 64'h9999AAAA);
    chk("t7_w2_clr", 64'(data_reg[2]), 64'd0);
    tick();
    chk("t7_idle", 64'(rd_state_r), 64'(RD_IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
